// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demultiplexer: routes one valid/ready stream to one of four lanes,
// each lane backed by a single-entry holding register so a stalled lane never blocks the rest.
module demux1to4_buf #(
  parameter int unsigned WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [2:0]           pending
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 3;

  logic [LANES-1:0] full_q, full_d;
  logic [WIDTH-1:0] hold_q [LANES];
  logic [WIDTH-1:0] hold_d [LANES];
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             accept;

  // Next-state: drains clear lanes first, then an accept (re)fills the selected lane.
  always_comb begin
    in_ready  = !full_q[sel] | out_ready[sel];
    accept    = in_valid & in_ready;
    full_d    = full_q & ~out_ready;
    hold_d    = hold_q;
    pending_d = '0;
    if (accept) begin
      full_d[sel] = 1'b1;
      hold_d[sel] = in_data;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      pending_d = pending_d + CNT_W'(full_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      full_q    <= full_d;
      pending_q <= pending_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign out_valid = full_q;
  assign pending   = pending_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign out_data[g*WIDTH +: WIDTH] = hold_q[g];
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: per-lane queue model checked every cycle, plus directed literal checks.
module tb_demux1to4_buf;

  localparam int unsigned W = 128;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     sel;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [2:0]     pending;

  int total = 0;
  int bad   = 0;

  demux1to4_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Model: each lane is a queue of words awaiting its consumer, plus the last word ever routed there.
  logic [W-1:0] mq [4][$];
  logic [W-1:0] mlast [4];

  initial for (int i = 0; i < 4; i++) mlast[i] = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mlast[i] = '0;
      end
    end else begin
      automatic bit acc = in_valid && (mq[sel].size() == 0 || out_ready[sel]);
      automatic int s = int'(sel);
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
      end
      if (acc) begin
        mq[s].push_back(in_data);
        mlast[s] = in_data;
      end
    end
  end

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; in reset everything must read as empty.
  always @(negedge clk) begin
    automatic int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cnt += mq[i].size();
      chk($sformatf("valid%0d", i), W'(out_valid[i]), rst_n ? W'(mq[i].size() != 0) : W'(0));
      chk($sformatf("data%0d", i), lane(i), rst_n ? mlast[i] : W'(0));
    end
    chk("pending", W'(pending), rst_n ? W'(cnt) : W'(0));
    chk("in_ready", W'(in_ready),
        (!rst_n || mq[sel].size() == 0 || out_ready[sel]) ? W'(1) : W'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit stalled;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = 2'd0; out_ready = 4'b0000;
    @(negedge clk);
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_pending", W'(pending), W'(0));
    chk("rst_data", W'(out_data != '0), W'(0));
    step(); step();
    rst_n = 1'b1;

    // Route a word to lane 2, then drain it
    in_valid = 1'b1; in_data = W'(128'hA5); sel = 2'd2;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("route_valid", W'(out_valid), W'(4'b0100));
    chk("route_data", lane(2), W'(128'hA5));
    chk("route_pending", W'(pending), W'(1));
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    @(negedge clk);
    chk("route_drain", W'(out_valid), W'(0));

    // Stalled lane 1 must not block lane 3
    step();
    in_valid = 1'b1; sel = 2'd1; in_data = W'(128'hB1);
    step();
    in_data = W'(128'hB2);
    @(negedge clk);
    chk("stall_ready", W'(in_ready), W'(0));
    step();
    @(negedge clk);
    chk("stall_hold", lane(1), W'(128'hB1));
    sel = 2'd3; in_data = W'(128'hC3);
    #1;
    chk("iso_ready", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("iso_valid", W'(out_valid), W'(4'b1010));
    chk("iso_lane1", lane(1), W'(128'hB1));
    chk("iso_lane3", lane(3), W'(128'hC3));

    // Pass-through on lane 0 at one word per cycle
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0001; in_valid = 1'b1; sel = 2'd0; in_data = W'(1);
    @(negedge clk);
    chk("pt_ready1", W'(in_ready), W'(1));
    step();
    in_data = W'(2);
    @(negedge clk);
    chk("pt_data1", lane(0), W'(1));
    chk("pt_ready2", W'(in_ready), W'(1));
    step();
    in_data = W'(3);
    @(negedge clk);
    chk("pt_data2", lane(0), W'(2));
    chk("pt_ready3", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pt_data3", lane(0), W'(3));
    chk("pt_valid3", W'(out_valid), W'(4'b0001));
    step();
    @(negedge clk);
    chk("pt_empty", W'(out_valid), W'(0));

    // All lanes full, then drain everything while refilling lane 0
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel = 2'(i); in_data = W'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_pending", W'(pending), W'(4));
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("full_ready%0d", s), W'(in_ready), W'(0));
    end
    out_ready = 4'b1111; in_valid = 1'b1; sel = 2'd0; in_data = W'(8'h20);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    chk("refill_data", lane(0), W'(8'h20));
    chk("refill_valid", W'(out_valid), W'(4'b0001));
    chk("refill_pending", W'(pending), W'(1));

    // Asynchronous reset with lanes 0 and 2 full
    in_valid = 1'b1; sel = 2'd2; in_data = W'(8'h22);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", W'(out_valid), W'(4'b0101));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(out_valid), W'(0));
    chk("arst_pending", W'(pending), W'(0));
    chk("arst_data", W'(out_data != '0), W'(0));
    step();
    rst_n = 1'b1;

    // Random traffic; the source holds its word while stalled
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      stalled = in_valid && !in_ready;
      step();
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 2'($urandom_range(0, 3));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = 4'($urandom);
    end

    in_valid = 1'b0; out_ready = 4'b1111;
    step(); step();
    @(negedge clk);
    chk("final_pending", W'(pending), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
